// File: rtl/irq_ctrl.sv
// Interrupt responder: edge-detects requests, arbitrates, saves the return PC and supplies the handler vector.
// Optional IRQ_PRIO_ROTATE_EN: round-robin priority pointer instead of fixed priority (bit 0 highest).
module irq_ctrl #(
  parameter logic [9:0] VEC_BASE   = 10'h3C0,
  parameter logic [9:0] VEC_STRIDE = 10'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       int_ack,
  input  logic       reti,
  input  logic [9:0] pc_in,
  input  logic       mask_we,
  input  logic [7:0] mask_d,
  output logic       int_req,
  output logic       in_service,
  output logic [1:0] irq_id,
  output logic [9:0] vector,
  output logic [9:0] pc_ret,
  output logic [3:0] pending,
  output logic [3:0] mask_q
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t     state_q, state_d;
  logic [3:0] irq_prev_q;
  logic [3:0] pending_q, pending_d, pending_clr;
  logic [3:0] mask_upd_d;
  logic [1:0] irq_id_q, irq_id_d;
  logic [9:0] vector_q, vector_d;
  logic [9:0] pc_ret_q, pc_ret_d;
  logic [3:0] active;
  logic       any_act;
  logic [1:0] winner, scan_base, idx;
  logic       found;

`ifdef IRQ_PRIO_ROTATE_EN
  logic [1:0] ptr_q, ptr_d;
  always_comb scan_base = ptr_q;
`else
  always_comb scan_base = 2'd0;
`endif

  assign active  = pending_q & mask_q;
  assign any_act = |active;

  // First enabled pending source scanning upward from scan_base with wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = scan_base + i[1:0];
      if (!found && active[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_clr = '0;
    irq_id_d    = irq_id_q;
    vector_d    = vector_q;
    pc_ret_d    = pc_ret_q;
`ifdef IRQ_PRIO_ROTATE_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: if (any_act) state_d = REQ;
      REQ: begin
        // An ack arriving as the mask withdraws the last source is not honoured.
        if (int_ack && any_act) begin
          irq_id_d            = winner;
          pc_ret_d            = pc_in;
          vector_d            = VEC_BASE + {8'd0, winner} * VEC_STRIDE;
          pending_clr[winner] = 1'b1;
          state_d             = SERV;
`ifdef IRQ_PRIO_ROTATE_EN
          ptr_d               = winner + 2'd1;
`endif
        end else if (!any_act) begin
          state_d = IDLE;
        end
      end
      SERV: if (reti) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d  = (pending_q & ~pending_clr) | (irq & ~irq_prev_q);
    mask_upd_d = mask_we ? mask_d[3:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_id_q   <= '0;
      vector_q   <= '0;
      pc_ret_q   <= '0;
`ifdef IRQ_PRIO_ROTATE_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      pending_q  <= pending_d;
      mask_q     <= mask_upd_d;
      irq_id_q   <= irq_id_d;
      vector_q   <= vector_d;
      pc_ret_q   <= pc_ret_d;
`ifdef IRQ_PRIO_ROTATE_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign int_req    = (state_q == REQ);
  assign in_service = (state_q == SERV);
  assign irq_id     = irq_id_q;
  assign vector     = vector_q;
  assign pc_ret     = pc_ret_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl; acceptance results go through a scoreboard queue.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       int_ack, reti, mask_we;
  logic [9:0] pc_in;
  logic [7:0] mask_d;
  logic       int_req, in_service;
  logic [1:0] irq_id;
  logic [9:0] vector, pc_ret;
  logic [3:0] pending, mask_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [9:0] vec;
    logic [9:0] pc;
  } exp_t;
  exp_t sb[$];

  irq_ctrl #(.VEC_BASE(10'h3C0), .VEC_STRIDE(10'd4)) dut (
    .clk(clk), .reset(reset), .irq(irq), .int_ack(int_ack), .reti(reti),
    .pc_in(pc_in), .mask_we(mask_we), .mask_d(mask_d), .int_req(int_req),
    .in_service(in_service), .irq_id(irq_id), .vector(vector), .pc_ret(pc_ret),
    .pending(pending), .mask_q(mask_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_d  = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  // Push the expected acceptance, ack, then pop once the handler is running.
  task automatic do_ack(input logic [1:0] id, input logic [9:0] vec, input logic [9:0] pc);
    exp_t e;
    int   n;
    pc_in = pc;
    sb.push_back('{id: id, vec: vec, pc: pc});
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    n = 0;
    while (!in_service && n < 4) begin
      tick();
      n++;
    end
    check("svc_start", in_service, 1'b1);
    check("ack_int_req", int_req, 1'b0);
    e = sb.pop_front();
    check("irq_id", irq_id, e.id);
    check("vector", vector, e.vec);
    check("pc_ret", pc_ret, e.pc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_int_req"}, int_req, 1'b0);
    check({tag, "_in_service"}, in_service, 1'b0);
    check({tag, "_irq_id"}, irq_id, 2'd0);
    check({tag, "_vector"}, vector, 10'd0);
    check({tag, "_pc_ret"}, pc_ret, 10'd0);
    check({tag, "_pending"}, pending, 4'd0);
  endtask

  initial begin
    reset = 1'b1; irq = '0; int_ack = 1'b0; reti = 1'b0;
    pc_in = '0; mask_we = 1'b0; mask_d = '0;
    tick(); tick();
    check_zero("rst");
    check("rst_mask", mask_q, 4'h0);
    reset = 1'b0;

    // Single timer event, line held high
    write_mask(8'hF1);
    check("mask_upper_ignored", mask_q, 4'h1);
    irq = 4'b0001; pc_in = 10'h025;
    tick();
    check("t_pending", pending, 4'b0001);
    check("t_req_early", int_req, 1'b0);
    tick();
    check("t_req", int_req, 1'b1);
    do_ack(2'd0, 10'h3C0, 10'h025);
    check("t_pending_clr", pending, 4'b0000);
    do_reti();
    check("t_reti_idle", in_service, 1'b0);
    tick(); tick();
    check("t_no_rereq", int_req, 1'b0);
    check("t_no_repend", pending, 4'b0000);

    // Simultaneous sources
    irq = '0;
    write_mask(8'h0F);
    irq = 4'b0110;
    tick();
    check("s_pending", pending, 4'b0110);
    tick();
    check("s_req", int_req, 1'b1);
    do_ack(2'd1, 10'h3C4, 10'h100);
    check("s_pending1", pending, 4'b0100);
    do_reti();
    check("s_reti_noreq", int_req, 1'b0);
    tick();
    check("s_rereq", int_req, 1'b1);
    do_ack(2'd2, 10'h3C8, 10'h1AB);
    check("s_pending2", pending, 4'b0000);
    do_reti();
    irq = '0;
    tick();

    // Masked edge
    write_mask(8'h00);
    irq = 4'b1000;
    tick();
    irq = '0;
    tick();
    check("m_pending", pending, 4'b1000);
    check("m_noreq", int_req, 1'b0);
    tick();
    check("m_noreq2", int_req, 1'b0);
    write_mask(8'h08);
    check("m_mask", mask_q, 4'h8);
    check("m_req_early", int_req, 1'b0);
    tick();
    check("m_req", int_req, 1'b1);

    // Withdrawn request
    write_mask(8'h00);
    check("w_req_hold", int_req, 1'b1);
    tick();
    check("w_req_drop", int_req, 1'b0);
    check("w_pending", pending, 4'b1000);
    tick();
    check("w_idle", int_req, 1'b0);

    // Reset during service, then stray ack in IDLE
    write_mask(8'h08);
    tick();
    check("r_req", int_req, 1'b1);
    do_ack(2'd3, 10'h3CC, 10'h3FF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("r_abort");
    check("r_mask", mask_q, 4'h0);
    int_ack = 1'b1; pc_in = 10'h155;
    tick();
    int_ack = 1'b0;
    check_zero("r_stray");

    // Line high as reset releases counts as an edge
    reset = 1'b1; irq = 4'b0100;
    tick();
    reset = 1'b0;
    check("rr_in_reset", pending, 4'b0000);
    tick();
    check("rr_edge", pending, 4'b0100);

    // Priority after servicing source 0 with a fresh source-0 edge
    irq = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    write_mask(8'h0F);
    irq = 4'b0011;
    tick();
    irq = '0;
    tick();
    check("p_req", int_req, 1'b1);
    do_ack(2'd0, 10'h3C0, 10'h010);
    check("p_pending1", pending, 4'b0010);
    irq = 4'b0001;
    tick();
    irq = '0;
    check("p_pending_serv", pending, 4'b0011);
    do_reti();
    tick();
    check("p_rereq", int_req, 1'b1);
`ifdef IRQ_PRIO_ROTATE_EN
    do_ack(2'd1, 10'h3C4, 10'h020);
    check("p_pending2", pending, 4'b0001);
`else
    do_ack(2'd0, 10'h3C0, 10'h020);
    check("p_pending2", pending, 4'b0010);
`endif
    do_reti();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt responder for the 8-bit CPU. It receives interrupt requests from the timer and peripherals and arbitrates between them.
- It requests service from the control unit, then, on acknowledge, saves the return PC and supplies a handler vector. It restores that PC on return-from-interrupt.
- It sits between the timer/peripheral request lines and the PC mux.

Parameters:
- VEC_BASE, 10'h3C0, PC address of the handler for source 0.
- VEC_STRIDE, 4, address spacing between consecutive handler entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- irq  in  4  request lines; bit 0 is the timer. Lines may stay high indefinitely.
- int_ack  in  1  control unit accepts the request at an instruction boundary.
- reti  in  1  control unit executes return-from-interrupt.
- pc_in  in  10  current PC (next instruction address), captured on accept.
- mask_we  in  1  write enable for the mask register.
- mask_d  in  8  mask write data; bits [3:0] are used, [7:4] are ignored.
- int_req  out  1  interrupt request to the control unit.
- in_service  out  1  a handler is executing.
- irq_id  out  2  id of the source being serviced.
- vector  out  10  handler address, VEC_BASE + irq_id*VEC_STRIDE.
- pc_ret  out  10  saved return PC, to the PC mux on reti.
- pending  out  4  pending register.
- mask_q  out  4  mask register; 1 = source enabled.

Behaviour:
- Reset (synchronous): state IDLE, int_req=0, in_service=0, irq_id=0, vector=0, pc_ret=0, pending=0, mask_q=0, irq_prev=0. Reset asserted mid-service aborts the service with no saved state kept.
- Edge detect:
  - irq_prev <= irq every cycle.
  - A rising edge on bit k (irq[k]=1, irq_prev[k]=0) sets pending[k] on that clock edge.
  - A line high when reset releases counts as an edge on the first cycle after reset.
  - A constantly-high line produces exactly one pending event.
- Pending capture is independent of mask: masked edges still set pending.
- pending[k] clears only when source k is accepted. If a new edge and the clear for k occur in the same cycle, set wins.
- Mask: mask_q <= mask_d[3:0] when mask_we is high, in any state. The new mask is effective from the next cycle.
- Arbitration: the winner is the lowest k with pending[k] & mask_q[k]. It is evaluated combinationally every cycle.
- FSM:
  - IDLE: if any (pending & mask_q) is set, go to REQ.
  - REQ: int_req=1 (decoded from state).
    - If int_ack: irq_id <= winner, pc_ret <= pc_in, vector <= VEC_BASE + winner*VEC_STRIDE, clear pending[winner], go to SERV.
    - Else if (pending & mask_q)==0 (masked off): go to IDLE, int_req drops.
    - Else stay in REQ.
  - SERV: in_service=1, int_req=0. New edges keep accumulating in pending. No nesting.
    - If reti: go to IDLE; irq_id, vector and pc_ret hold their values.
- Ignored inputs: int_ack outside REQ and reti outside SERV have no effect.
- Latency:
  - Edge sampled at edge n → pending visible after n → int_req high after edge n+1.
  - Ack at edge m → in_service, vector and pc_ret valid after m.
  - reti at edge r → IDLE after r → int_req again after r+1 if work remains.
- Arithmetic: vector is computed in 10 bits and wraps modulo 1024; irq_id*VEC_STRIDE is truncated to 10 bits.
- All outputs are registered or decoded from state only; there is no combinational input→output path.

Optional Feature:
- Macro IRQ_PRIO_ROTATE_EN.
- Defined: a 2-bit rotation pointer (reset 0) sets the highest-priority source. After accepting source k, the pointer becomes (k+1) mod 4. The winner is the first enabled pending source found scanning from the pointer upward with wrap.
- Undefined: fixed priority, bit 0 highest; no pointer register exists.

Test Plan:
- Single timer event:
  - Stimulus: after reset, mask_we=1, mask_d=8'h01, irq[0] 0→1 and held high, pc_in=10'h025.
  - Required: int_req rises 2 cycles after the edge. On int_ack: vector=10'h3C0, pc_ret=10'h025, in_service=1, pending=0. After reti, no new int_req while irq[0] stays high.
- Simultaneous sources:
  - Stimulus: mask=4'hF, irq 0000→0110 in one cycle.
  - Required: first ack gives irq_id=1, vector=10'h3C4, pending=0100. After reti, int_req returns; second ack gives irq_id=2, vector=10'h3C8.
- Masked edge:
  - Stimulus: mask=0, pulse irq[3] for one cycle.
  - Required: pending=1000, int_req=0. Writing mask=4'h8 brings int_req=1 two cycles after the write.
- Withdrawn request:
  - Stimulus: in REQ, write mask=0 with no int_ack.
  - Required: int_req drops, state returns to IDLE, pending is unchanged.
- Reset and stray controls:
  - Stimulus: reset during SERV, then int_ack in IDLE.
  - Required: after reset all outputs are 0 and state is IDLE. int_ack in IDLE changes nothing.
- Rotation (IRQ_PRIO_ROTATE_EN defined):
  - Stimulus: mask=4'hF; pending 0011 via edges.
  - Required: source 0 is serviced first. A new edge on irq[0] arrives during SERV; after reti, source 1 wins over source 0.
